// File: rtl/ball_motion.sv
// Ball kinematics for Breakout: parks the ball on the paddle until a serve,
// then steps it once per frame tick with wall, brick and paddle bounces.
// Handshake note: there are no valid/ready pairs here. tick, serve and
// brick_hit are plain strobes sampled on the rising clk edge, and every
// output is a registered level or a single-clk pulse.
module ball_motion #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 100,
    parameter int PADDLE_Y  = 440,
    parameter int STEP      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       serve,
    input  logic [9:0] paddle_pos,
    input  logic       brick_hit,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_active,
    output logic       paddle_hit,
    output logic       miss
);

    // 11-bit constants so that position sums never wrap in the compares
    localparam logic [10:0] HR      = 11'(H_RES);
    localparam logic [10:0] VR      = 11'(V_RES);
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PY      = 11'(PADDLE_Y);
    localparam logic [10:0] ST      = 11'(STEP);
    localparam logic [10:0] BS_HALF = 11'(BALL_SIZE / 2);
    localparam logic [10:0] PW_HALF = 11'(PADDLE_W / 2);
    localparam logic [9:0]  PARK_Y  = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]  RESET_X = 10'(H_RES / 2 - BALL_SIZE / 2);

    typedef enum logic [1:0] {IDLE, PLAY, MISS} state_t;

    state_t      state;
    logic        dx;
    logic        dy;
    logic        brick_latch;

    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] p_w;
    logic        latch_now;
    logic        miss_det;
    logic        pad_det;
    logic        top_det;
    logic        eff_dx;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic        next_dx;
    logic        next_dy;

    assign x_w = {1'b0, ball_x};
    assign y_w = {1'b0, ball_y};
    assign p_w = {1'b0, paddle_pos};

    // Next position/direction for a PLAY tick; y rules are prioritised, x is independent
    always_comb begin
        latch_now = brick_latch | brick_hit;
        miss_det  = dy && (y_w + BS + ST >= VR);
        pad_det   = dy && (y_w + BS <= PY) && (PY <= y_w + BS + ST)
                       && (x_w + BS > p_w) && (x_w < p_w + PW);
        top_det   = !dy && (y_w <= ST);

        next_y  = ball_y;
        next_dy = dy;
        if (pad_det) begin
            next_y  = PARK_Y;
            next_dy = 1'b0;
        end else if (top_det) begin
            next_y  = 10'd0;
            next_dy = 1'b1;
        end else if (latch_now) begin
            // reverse first, then step; a reversal right at the top clamps to 0
            next_dy = !dy;
            if (dy) next_y = (y_w <= ST) ? 10'd0 : 10'(y_w - ST);
            else    next_y = 10'(y_w + ST);
        end else if (dy) begin
            next_y = 10'(y_w + ST);
        end else begin
            next_y = 10'(y_w - ST);
        end

        // paddle english: hitting left of centre sends the ball left
        eff_dx = pad_det ? (x_w + BS_HALF >= p_w + PW_HALF) : dx;
        if (!eff_dx && (x_w <= ST)) begin
            next_x  = 10'd0;
            next_dx = 1'b1;
        end else if (eff_dx && (x_w + BS + ST >= HR)) begin
            next_x  = 10'(HR - BS);
            next_dx = 1'b0;
        end else begin
            next_x  = eff_dx ? 10'(x_w + ST) : 10'(x_w - ST);
            next_dx = eff_dx;
        end
    end

    // Control FSM with registered position, direction, latch and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dx          <= 1'b1;
            dy          <= 1'b0;
            ball_x      <= RESET_X;
            ball_y      <= PARK_Y;
            ball_active <= 1'b0;
            paddle_hit  <= 1'b0;
            miss        <= 1'b0;
            brick_latch <= 1'b0;
        end else begin
            paddle_hit <= 1'b0;
            miss       <= 1'b0;
            case (state)
                IDLE: begin
                    ball_x      <= 10'(p_w + PW_HALF - BS_HALF);
                    ball_y      <= PARK_Y;
                    brick_latch <= 1'b0;
                    if (serve) begin
                        state       <= PLAY;
                        dx          <= 1'b1;
                        dy          <= 1'b0;
                        ball_active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        brick_latch <= 1'b0;
                        if (miss_det) begin
                            state       <= MISS;
                            miss        <= 1'b1;
                            ball_active <= 1'b0;
                        end else begin
                            ball_x     <= next_x;
                            ball_y     <= next_y;
                            dx         <= next_dx;
                            dy         <= next_dy;
                            paddle_hit <= pad_det;
                        end
                    end else if (brick_hit) begin
                        brick_latch <= 1'b1;
                    end
                end
                MISS: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball kinematics stage for the Breakout datapath. It sits directly downstream of the paddle controller and consumes its 10-bit `paddle_pos` (left edge, x-pixel). It moves the ball one step per frame tick and handles bounces off the walls, bricks and paddle. It reports misses and paddle hits, and drives `ball_x`/`ball_y` to the renderer and brick-collision logic.

## Interface
- `H_RES`, 640, horizontal playfield width in pixels
- `V_RES`, 480, vertical playfield height in pixels
- `BALL_SIZE`, 8, ball square side in pixels
- `PADDLE_W`, 100, paddle width in pixels
- `PADDLE_Y`, 440, y of paddle top edge
- `STEP`, 2, pixels moved per tick on each axis
- `clk` input 1: system clock
- `reset` input 1: synchronous, active-high
- `tick` input 1: one-clk frame strobe; all motion updates happen only on it
- `serve` input 1: launch request, level or pulse
- `paddle_pos` input 10: paddle left edge, from the paddle stage
- `brick_hit` input 1: one-clk pulse from brick logic; requests a vertical reversal
- `ball_x` output 10: ball top-left x
- `ball_y` output 10: ball top-left y
- `ball_active` output 1: high while the FSM is in PLAY
- `paddle_hit` output 1: one-clk pulse on a paddle bounce
- `miss` output 1: one-clk pulse when the ball leaves the bottom edge

## Operation
- **FSM states:** IDLE, PLAY, MISS.
- **Direction registers:** `dx`, `dy` (1 = positive).
- **Reset:**
  - state = IDLE, `dx` = 1, `dy` = 0 (upward).
  - `ball_x` = 316, `ball_y` = 432.
  - `ball_active` = 0, `paddle_hit` = 0, `miss` = 0.
  - Brick latch cleared.
- **IDLE:**
  - Every clk (not only on tick), the ball is parked on the paddle: `ball_x` = `paddle_pos` + PADDLE_W/2 − BALL_SIZE/2, `ball_y` = PADDLE_Y − BALL_SIZE.
  - If `serve` = 1: go to PLAY and set `dx` = 1, `dy` = 0.
  - `brick_hit` is ignored.
- **Brick latch:**
  - A `brick_hit` pulse in PLAY sets the latch.
  - The latch is consumed and cleared on the next tick.
  - A `brick_hit` arriving in the same clk as a tick is consumed by that tick.
- **PLAY, on tick:** the first matching rule sets `dy` and `ball_y`.
  1. Miss: `dy` = 1 and `ball_y` + BALL_SIZE + STEP ≥ V_RES → go to MISS; `ball_x`/`ball_y` hold.
  2. Paddle: all of the following hold:
     - `dy` = 1;
     - `ball_y` + BALL_SIZE ≤ PADDLE_Y ≤ `ball_y` + BALL_SIZE + STEP;
     - `ball_x` + BALL_SIZE > `paddle_pos`;
     - `ball_x` < `paddle_pos` + PADDLE_W.

     Then `ball_y` = PADDLE_Y − BALL_SIZE and `dy` = 0. `dx` = 0 if ball centre (`ball_x` + 4) < paddle centre (`paddle_pos` + 50), else `dx` = 1. Pulse `paddle_hit`. The brick latch is discarded.
  3. Top: `dy` = 0 and `ball_y` ≤ STEP → `ball_y` = 0, `dy` = 1.
  4. Brick latch set → invert `dy`, then step `ball_y` by STEP in the new direction.
  5. Otherwise `ball_y` ± STEP.
- **PLAY, x axis (same tick, independent of y; skipped on miss):**
  - Left wall: `dx` = 0 and `ball_x` ≤ STEP → `ball_x` = 0, `dx` = 1.
  - Right wall: `dx` = 1 and `ball_x` + BALL_SIZE + STEP ≥ H_RES → `ball_x` = H_RES − BALL_SIZE, `dx` = 0.
  - On a paddle hit, `dx` is the paddle-selected value and `ball_x` steps in that direction with the wall clamps applied.
  - Otherwise `ball_x` ± STEP.
- `serve` in PLAY or MISS is ignored.
- **MISS:**
  - Lasts exactly one clk; `miss` is high during it.
  - Then go to IDLE; the ball re-parks on the next clk.
- **Arithmetic:** 11-bit unsigned compares so sums never wrap; positions never go below 0 or above the clamp values.

## Timing
- All outputs are registered.
- Position, `dx`/`dy` and state change in the clk after the tick edge; `paddle_hit` is high for that same single clk.
- `miss` is high in the clk after the tick that detects the miss; IDLE follows one clk later.
- `ball_active` is high from the clk after `serve` until the clk after the miss tick (`ball_active` = 0 while in MISS).
- No ticks are needed between a MISS and re-serve.
- Reset mid-operation overrides everything in the same edge: return to IDLE with the reset values above.

## Test plan
- **Reset, then serve:** reset, `paddle_pos` = 270, serve, one tick → `ball_x` = 318, `ball_y` = 430, `ball_active` = 1.
- **IDLE tracking:** in IDLE, `paddle_pos` 270 → 100 with no tick → `ball_x` = 146 on the next clk, `ball_y` = 432.
- **Walls:**
  - Serve from `paddle_pos` = 270; after 157 ticks → `ball_x` = 630; next tick → `ball_x` = 632, `dx` = 0.
  - On the way up, `ball_y` reaches 2; next tick → `ball_y` = 0, then 2.
- **Paddle bounce with english:**
  - Setup: ball descending at `ball_y` = 430, `ball_x` = 300, `paddle_pos` = 270.
  - Tick → `ball_y` = 432, `dy` = 0, `dx` = 0 (centre 304 < 320), `paddle_hit` pulse for 1 clk.
- **Miss:**
  - Setup: ball descending with `paddle_pos` = 0, `ball_x` = 400, `ball_y` = 470.
  - Tick → `miss` for 1 clk, `ball_active` = 0, then IDLE re-park at `paddle_pos` + 46.
- **Brick and reset corners:**
  - `brick_hit` coincident with a paddle-hit tick → only the paddle bounce occurs, and the following tick moves the ball up.
  - Reset asserted mid-PLAY → IDLE, `ball_x` = `paddle_pos` + 46, latch cleared.
